// File: rtl/bus_arbiter_if.sv
// Handshake and grant signals between the two bus masters and the arbiter.
// Latency: none, plain wires.
// Backpressure: masters hold req until granted; the arbiter throttles by withholding grant.
interface bus_arbiter_if;
    logic m1_req;
    logic m2_req;
    logic master_valid;
    logic tx_done;
    logic split_en;
    logic split_done;
    logic m1_grant;
    logic m2_grant;
    logic msel;
    logic m1_split;
    logic m2_split;
    logic bus_busy;

    // Requester side: drives requests and slave pulses, observes grants
    modport master (
        output m1_req, m2_req, master_valid, tx_done, split_en, split_done,
        input  m1_grant, m2_grant, msel, m1_split, m2_split, bus_busy
    );

    // Arbiter side
    modport slave (
        input  m1_req, m2_req, master_valid, tx_done, split_en, split_done,
        output m1_grant, m2_grant, msel, m1_split, m2_split, bus_busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master bus arbiter with one parked split transaction and a start timeout.
// Latency: grant one cycle after a request is sampled in IDLE; all outputs registered.
// Backpressure: a request waits while the bus is owned; a parked master is ignored until resumed.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Master encoding used by owner/last_owner/split_owner/msel: 0 = master 1, 1 = master 2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic             started_q, started_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             split_valid_q, split_valid_d;
    logic             split_owner_q, split_owner_d;
    logic             resume_pending_q, resume_pending_d;
    logic             m1_grant_q, m1_grant_d;
    logic             m2_grant_q, m2_grant_d;
    logic             msel_q, msel_d;
    logic             m1_split_q, m1_split_d;
    logic             m2_split_q, m2_split_d;
    logic             bus_busy_q, bus_busy_d;

    logic             do_grant;
    logic             grant_who;
    logic             do_drop;
    logic             owner_req;
    logic             m1_elig;
    logic             m2_elig;

    assign owner_req = owner_q ? bus.m2_req : bus.m1_req;
    assign m1_elig   = bus.m1_req & ~m1_split_q;
    assign m2_elig   = bus.m2_req & ~m2_split_q;

    // Next-state, arbitration and output decode; everything defaults to hold
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_owner_d     = last_owner_q;
        started_d        = started_q;
        cnt_d            = cnt_q;
        split_valid_d    = split_valid_q;
        split_owner_d    = split_owner_q;
        resume_pending_d = resume_pending_q;
        m1_grant_d       = m1_grant_q;
        m2_grant_d       = m2_grant_q;
        msel_d           = msel_q;
        m1_split_d       = m1_split_q;
        m2_split_d       = m2_split_q;
        do_grant         = 1'b0;
        grant_who        = 1'b0;
        do_drop          = 1'b0;

        // Resume request is latched in any state but only acted on from IDLE,
        // so a resume never pre-empts the current owner.
        if (split_valid_q && bus.split_done) begin
            resume_pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (resume_pending_q) begin
                    do_grant         = 1'b1;
                    grant_who        = split_owner_q;
                    split_valid_d    = 1'b0;
                    resume_pending_d = 1'b0;
                    if (split_owner_q) begin
                        m2_split_d = 1'b0;
                    end else begin
                        m1_split_d = 1'b0;
                    end
                end else if (m1_elig && m2_elig) begin
                    do_grant  = 1'b1;
                    grant_who = ~last_owner_q;
                end else if (m1_elig) begin
                    do_grant  = 1'b1;
                    grant_who = 1'b0;
                end else if (m2_elig) begin
                    do_grant  = 1'b1;
                    grant_who = 1'b1;
                end
            end
            BUSY: begin
                if (bus.tx_done) begin
                    // Completion wins over a coincident split request.
                    do_drop      = 1'b1;
                    last_owner_d = owner_q;
                end else if (bus.split_en && !split_valid_q) begin
                    do_drop       = 1'b1;
                    split_valid_d = 1'b1;
                    split_owner_d = owner_q;
                    last_owner_d  = owner_q;
                    if (owner_q) begin
                        m2_split_d = 1'b1;
                    end else begin
                        m1_split_d = 1'b1;
                    end
                end else if (!started_q && !owner_req) begin
                    // Master withdrew before starting; no fairness update.
                    do_drop = 1'b1;
                end else if (!started_q && (cnt_q == CNT_LAST) && !bus.master_valid) begin
                    do_drop      = 1'b1;
                    last_owner_d = owner_q;
                end else begin
                    if (!started_q) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (bus.master_valid) begin
                        started_d = 1'b1;
                    end
                end
            end
            default: begin
                do_drop = 1'b1;
            end
        endcase

        if (do_grant) begin
            state_d    = BUSY;
            owner_d    = grant_who;
            m1_grant_d = ~grant_who;
            m2_grant_d = grant_who;
            msel_d     = grant_who;
            cnt_d      = '0;
            started_d  = 1'b0;
        end

        if (do_drop) begin
            state_d    = IDLE;
            m1_grant_d = 1'b0;
            m2_grant_d = 1'b0;
        end

        bus_busy_d = m1_grant_d | m2_grant_d;
    end

    // State and output registers with synchronous reset; master 2 is last owner so master 1 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            owner_q          <= 1'b0;
            last_owner_q     <= 1'b1;
            started_q        <= 1'b0;
            cnt_q            <= '0;
            split_valid_q    <= 1'b0;
            split_owner_q    <= 1'b0;
            resume_pending_q <= 1'b0;
            m1_grant_q       <= 1'b0;
            m2_grant_q       <= 1'b0;
            msel_q           <= 1'b0;
            m1_split_q       <= 1'b0;
            m2_split_q       <= 1'b0;
            bus_busy_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_owner_q     <= last_owner_d;
            started_q        <= started_d;
            cnt_q            <= cnt_d;
            split_valid_q    <= split_valid_d;
            split_owner_q    <= split_owner_d;
            resume_pending_q <= resume_pending_d;
            m1_grant_q       <= m1_grant_d;
            m2_grant_q       <= m2_grant_d;
            msel_q           <= msel_d;
            m1_split_q       <= m1_split_d;
            m2_split_q       <= m2_split_d;
            bus_busy_q       <= bus_busy_d;
        end
    end

    assign bus.m1_grant = m1_grant_q;
    assign bus.m2_grant = m2_grant_q;
    assign bus.msel     = msel_q;
    assign bus.m1_split = m1_split_q;
    assign bus.m2_split = m2_split_q;
    assign bus.bus_busy = bus_busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with a grant scoreboard.
// Latency: expected grant cycles are pushed when stimulus is driven, compared on grant rise.
// Backpressure: n/a; bench holds requests as a real master would.
module tb_bus_arbiter;

    localparam int unsigned TIMEOUT = 16;
    localparam logic [1:0]  M1      = 2'b01;
    localparam logic [1:0]  M2      = 2'b10;

    logic clk = 1'b0;
    logic reset;

    bus_arbiter_if bif();

    bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; cyc is then the current cycle.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_grant(input logic [1:0] who, input int unsigned delta);
        exp_t e;
        e.who = who;
        e.cyc = cyc + delta;
        sb_q.push_back(e);
    endtask

    task automatic pulse_valid();
        bif.master_valid = 1'b1;
        tick(1);
        bif.master_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_m1_grant"}, bif.m1_grant, 0);
        check_eq({pfx, "_m2_grant"}, bif.m2_grant, 0);
        check_eq({pfx, "_msel"},     bif.msel,     0);
        check_eq({pfx, "_m1_split"}, bif.m1_split, 0);
        check_eq({pfx, "_m2_split"}, bif.m2_split, 0);
        check_eq({pfx, "_bus_busy"}, bif.bus_busy, 0);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each grant rise
    initial begin
        logic [1:0] prev_g;
        logic [1:0] cur_g;
        logic [1:0] rise;
        exp_t       e;
        prev_g = 2'b00;
        forever begin
            @(negedge clk);
            cur_g = {bif.m2_grant, bif.m1_grant};
            check_eq("excl", bif.m1_grant & bif.m2_grant, 0);
            check_eq("busy", bif.bus_busy, bif.m1_grant | bif.m2_grant);
            rise = cur_g & ~prev_g;
            if (rise != 2'b00) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexp_grant", rise, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("grant_who",  rise,     e.who);
                    check_eq("grant_cyc",  cyc,      e.cyc);
                    check_eq("grant_msel", bif.msel, (e.who == M2));
                end
            end
            prev_g = cur_g;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        bif.m1_req       = 1'b0;
        bif.m2_req       = 1'b0;
        bif.master_valid = 1'b0;
        bif.tx_done      = 1'b0;
        bif.split_en     = 1'b0;
        bif.split_done   = 1'b0;
        tick(2);
        check_all_zero("rst");

        // 1: single master, grant the cycle after request, drop the cycle after tx_done
        reset      = 1'b0;
        bif.m1_req = 1'b1;
        expect_grant(M1, 1);
        tick(1);
        pulse_valid();
        tick(3);
        bif.tx_done = 1'b1;
        bif.m1_req  = 1'b0;
        tick(1);
        bif.tx_done = 1'b0;
        check_eq("s1_drop", bif.m1_grant, 0);
        check_eq("s1_busy", bif.bus_busy, 0);
        tick(2);

        // 2: both requesting, strict alternation starting with master 1
        do_reset();
        bif.m1_req = 1'b1;
        bif.m2_req = 1'b1;
        expect_grant(M1, 1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            pulse_valid();
            tick(1);
            bif.tx_done = 1'b1;
            if (i < 3) begin
                expect_grant((i % 2 == 0) ? M2 : M1, 2);
            end else begin
                bif.m1_req = 1'b0;
                bif.m2_req = 1'b0;
            end
            tick(1);
            bif.tx_done = 1'b0;
            check_eq("s2_gap", {bif.m2_grant, bif.m1_grant}, 0);
        end
        tick(3);
        check_eq("s2_msel_hold", bif.msel, 1);

        // 3: split m1, m2 runs, split_done does not pre-empt, m1 resumes over m2_req
        do_reset();
        bif.m1_req = 1'b1;
        expect_grant(M1, 1);
        tick(1);
        pulse_valid();
        bif.m2_req = 1'b1;
        tick(1);
        bif.split_en = 1'b1;
        expect_grant(M2, 2);
        tick(1);
        bif.split_en = 1'b0;
        check_eq("s3_m1_drop",  bif.m1_grant, 0);
        check_eq("s3_m1_split", bif.m1_split, 1);
        check_eq("s3_m2_split", bif.m2_split, 0);
        tick(1);
        pulse_valid();
        bif.split_done = 1'b1;
        tick(1);
        bif.split_done = 1'b0;
        bif.split_en   = 1'b1;
        tick(1);
        bif.split_en = 1'b0;
        tick(1);
        check_eq("s3_no_preempt",  bif.m2_grant, 1);
        check_eq("s3_still_split", bif.m1_split, 1);
        bif.tx_done = 1'b1;
        expect_grant(M1, 2);
        tick(1);
        bif.tx_done = 1'b0;
        check_eq("s3_m2_drop", bif.m2_grant, 0);
        tick(1);
        check_eq("s3_resume_split", bif.m1_split, 0);
        pulse_valid();
        bif.tx_done = 1'b1;
        bif.m1_req  = 1'b0;
        bif.m2_req  = 1'b0;
        tick(1);
        bif.tx_done = 1'b0;
        tick(2);

        // 4: start timeout revokes m2 after TIMEOUT cycles; m1 wins next
        do_reset();
        bif.m2_req = 1'b1;
        expect_grant(M2, 1);
        expect_grant(M1, TIMEOUT + 2);
        tick(1);
        bif.m1_req = 1'b1;
        tick(TIMEOUT - 1);
        check_eq("s4_hold", bif.m2_grant, 1);
        tick(1);
        check_eq("s4_timeout", bif.m2_grant, 0);
        tick(1);
        bif.m2_req = 1'b0;
        pulse_valid();
        bif.tx_done = 1'b1;
        bif.m1_req  = 1'b0;
        tick(1);
        bif.tx_done = 1'b0;
        tick(2);

        // 4b: request withdrawn before start releases the bus
        bif.m1_req = 1'b1;
        expect_grant(M1, 1);
        tick(1);
        bif.m1_req = 1'b0;
        tick(1);
        check_eq("s4_abort", bif.m1_grant, 0);
        tick(2);

        // 5: tx_done beats split_en; stray split_done has no effect
        bif.m1_req = 1'b1;
        expect_grant(M1, 1);
        tick(1);
        pulse_valid();
        bif.tx_done  = 1'b1;
        bif.split_en = 1'b1;
        bif.m1_req   = 1'b0;
        tick(1);
        bif.tx_done  = 1'b0;
        bif.split_en = 1'b0;
        check_eq("s5_drop",     bif.m1_grant, 0);
        check_eq("s5_m1_split", bif.m1_split, 0);
        check_eq("s5_m2_split", bif.m2_split, 0);
        bif.split_done = 1'b1;
        tick(1);
        bif.split_done = 1'b0;
        tick(2);
        bif.m2_req = 1'b1;
        expect_grant(M2, 1);
        tick(1);
        pulse_valid();
        bif.tx_done = 1'b1;
        bif.m2_req  = 1'b0;
        tick(1);
        bif.tx_done = 1'b0;
        check_eq("s5_m2_split_end", bif.m2_split, 0);
        tick(2);

        // 6: reset while m2 owns the bus and m1 is parked
        do_reset();
        bif.m1_req = 1'b1;
        expect_grant(M1, 1);
        tick(1);
        pulse_valid();
        bif.m2_req   = 1'b1;
        bif.split_en = 1'b1;
        expect_grant(M2, 2);
        tick(1);
        bif.split_en = 1'b0;
        tick(1);
        pulse_valid();
        reset = 1'b1;
        tick(1);
        check_all_zero("s6");
        reset = 1'b0;
        expect_grant(M1, 1);
        tick(1);
        pulse_valid();
        bif.tx_done = 1'b1;
        bif.m1_req  = 1'b0;
        bif.m2_req  = 1'b0;
        tick(1);
        bif.tx_done = 1'b0;
        tick(3);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
